// File: rtl/pong_pkg.sv
// Shared constants and helpers for the Pong score display: segment patterns and
// elaboration-time BCD conversion.
package pong_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [31:0] to_bcd(input int unsigned value, input int unsigned digits);
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < digits) begin
        r[i*4 +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return r;
  endfunction

  function automatic int unsigned pow10(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/pong_score_display_if.sv
// Bundles the game-side pulses and the score/segment outputs of the score display.
interface pong_score_display_if #(
    parameter int unsigned PLAYERS = 2,
    parameter int unsigned DIGITS  = 2
) ();

    localparam int unsigned WinW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

    logic [PLAYERS-1:0]          point;
    logic                        clear;
    logic [PLAYERS*DIGITS*4-1:0] score_bcd;
    logic                        game_over;
    logic [WinW-1:0]             winner;
    logic [PLAYERS*DIGITS*7-1:0] hex;

    modport master (
        output point, clear,
        input  score_bcd, game_over, winner, hex
    );

    modport slave (
        input  point, clear,
        output score_bcd, game_over, winner, hex
    );

endinterface

// File: rtl/pong_score_display_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes and blank show nothing.
module seg7_decoder
    import pong_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i && (bcd_i <= 4'd9)) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/pong_score_display.sv
// Per-player BCD score keeper with win latch and registered seven-segment output,
// blinking the winner's digits once the game is over.
module pong_score_display
    import pong_pkg::*;
#(
    parameter int unsigned PLAYERS   = 2,
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned WIN_SCORE = 11,
    parameter int unsigned BLINK_DIV = 12_500_000,
    parameter int unsigned LZB       = 1
) (
    input logic          clk,
    input logic          rst,
    pong_score_display_if.slave bus
);

    localparam int unsigned NDig = PLAYERS * DIGITS;
    localparam int unsigned SW   = DIGITS * 4;
    localparam int unsigned WinW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
    localparam int unsigned CntW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [31:0]   WinBcdAll = to_bcd(WIN_SCORE, DIGITS);
    localparam logic [SW-1:0] WinBcd    = WinBcdAll[SW-1:0];

    function automatic logic [NDig*7-1:0] reset_hex();
        logic [NDig*7-1:0] h;
        for (int unsigned k = 0; k < NDig; k++) begin
            h[k*7 +: 7] = (((k % DIGITS) == 0) || (LZB == 0)) ? SEG_DIGIT[0] : SEG_BLANK;
        end
        return h;
    endfunction

    localparam logic [NDig*7-1:0] HexRst = reset_hex();

    // Ripple increment; an all-nines score holds instead of wrapping.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic          carry;
        r     = s;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (s[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = s[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return carry ? s : r;
    endfunction

    if ((NDig > 8) || (PLAYERS == 0) || (DIGITS == 0)) begin : g_bad_size
        $error("pong_score_display: PLAYERS*DIGITS must be 1..8");
    end
    if (WIN_SCORE > pow10(DIGITS) - 1) begin : g_bad_win
        $error("pong_score_display: WIN_SCORE does not fit in DIGITS");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("pong_score_display: BLINK_DIV must be at least 1");
    end

    logic [PLAYERS-1:0][SW-1:0] score_q, score_d;
    logic                       go_q, go_d;
    logic [WinW-1:0]            win_q, win_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic                       ph_q, ph_d;
    logic [NDig*7-1:0]          hex_q;
    logic [NDig*7-1:0]          seg;
    logic [NDig-1:0]            blank;
    logic                       zero_run;

    always_comb begin
        score_d = score_q;
        go_d    = go_q;
        win_d   = win_q;
        if (bus.clear) begin
            score_d = '0;
            go_d    = 1'b0;
            win_d   = '0;
        end else if (!go_q) begin
            for (int i = 0; i < PLAYERS; i++) begin
                if (bus.point[i]) score_d[i] = bcd_inc(score_q[i]);
            end
            if (WIN_SCORE != 0) begin
                // Descending scan so the lowest-index winner is the last assignment.
                for (int i = PLAYERS - 1; i >= 0; i--) begin
                    if (score_d[i] == WinBcd) begin
                        go_d  = 1'b1;
                        win_d = WinW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (bus.clear || !go_q) begin
            cnt_d = '0;
            ph_d  = 1'b0;
        end else if (cnt_q == CntW'(BLINK_DIV - 1)) begin
            cnt_d = '0;
            ph_d  = !ph_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = 0; i < PLAYERS; i++) begin
            zero_run = 1'b1;
            for (int d = DIGITS - 1; d >= 0; d--) begin
                zero_run = zero_run && (score_q[i][d*4 +: 4] == 4'd0);
                blank[i*DIGITS + d] = (go_q && ph_q && (win_q == WinW'(i))) ||
                                      ((LZB != 0) && (d > 0) && zero_run);
            end
        end
    end

    for (genvar g = 0; g < NDig; g++) begin : g_dec
        seg7_decoder u_dec (
            .bcd_i  (score_q[g / DIGITS][(g % DIGITS)*4 +: 4]),
            .blank_i(blank[g]),
            .seg_o  (seg[g*7 +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q <= '0;
            go_q    <= 1'b0;
            win_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            hex_q   <= HexRst;
        end else begin
            score_q <= score_d;
            go_q    <= go_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            hex_q   <= seg;
        end
    end

    assign bus.score_bcd = score_q;
    assign bus.game_over = go_q;
    assign bus.winner    = win_q;
    assign bus.hex       = hex_q;

endmodule

// File: tb/tb_pong_score_display.sv
// Directed bench: a two-digit game with fast blink, plus a one-digit unlimited instance.
module tb_pong_score_display;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pong_score_display_if #(.PLAYERS(2), .DIGITS(2)) bus_a ();
    pong_score_display_if #(.PLAYERS(2), .DIGITS(1)) bus_b ();

    pong_score_display #(
        .PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .BLINK_DIV(4), .LZB(1)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    pong_score_display #(
        .PLAYERS(2), .DIGITS(1), .WIN_SCORE(0), .BLINK_DIV(4), .LZB(1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    typedef struct {
        logic [1:0]  point;
        logic        clear;
        logic [15:0] score;
        logic        go;
        logic        win;
    } vec_t;

    vec_t rows[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   seg_b_start;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            bus_a.point = rows[r].point;
            bus_a.clear = rows[r].clear;
            tick();
            bus_a.point = 2'b00;
            bus_a.clear = 1'b0;
            check($sformatf("row%0d score", r), 32'(bus_a.score_bcd), 32'(rows[r].score));
            check($sformatf("row%0d game_over", r), 32'(bus_a.game_over), 32'(rows[r].go));
            check($sformatf("row%0d winner", r), 32'(bus_a.winner), 32'(rows[r].win));
        end
    endtask

    initial begin
        // Ten points for player 0.
        for (int k = 1; k <= 10; k++) rows.push_back('{2'b01, 1'b0, {8'h00, bcd2(k)}, 1'b0, 1'b0});
        seg_b_start = rows.size();
        for (int k = 1; k <= 10; k++) rows.push_back('{2'b01, 1'b0, {8'h00, bcd2(k)}, 1'b0, 1'b0});
        for (int k = 1; k <= 10; k++) rows.push_back('{2'b10, 1'b0, {bcd2(k), 8'h10}, 1'b0, 1'b0});
        // Simultaneous win at 11: lowest index wins; further points ignored.
        rows.push_back('{2'b11, 1'b0, 16'h1111, 1'b1, 1'b0});
        rows.push_back('{2'b01, 1'b0, 16'h1111, 1'b1, 1'b0});
        rows.push_back('{2'b01, 1'b1, 16'h0000, 1'b0, 1'b0});
        for (int k = 1; k <= 10; k++) rows.push_back('{2'b10, 1'b0, {bcd2(k), 8'h00}, 1'b0, 1'b0});
        rows.push_back('{2'b10, 1'b0, 16'h1100, 1'b1, 1'b1});
        rows.push_back('{2'b10, 1'b0, 16'h1100, 1'b1, 1'b1});

        rst = 1'b1;
        bus_a.point = 2'b00;
        bus_a.clear = 1'b0;
        bus_b.point = 2'b00;
        bus_b.clear = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        check("reset hex_a", 32'(bus_a.hex), 32'({SB, S0, SB, S0}));
        check("reset hex_b", 32'(bus_b.hex), 32'({S0, S0}));
        check("reset score_a", 32'(bus_a.score_bcd), 32'h0);
        check("reset game_over", 32'(bus_a.game_over), 32'h0);

        run_rows(0, seg_b_start - 1);
        tick();
        check("hex after 10", 32'(bus_a.hex), 32'({SB, S0, S1, S0}));

        // Asynchronous reset mid-cycle, sampled before the next clock edge.
        #3 rst = 1'b1;
        #1;
        check("async rst hex", 32'(bus_a.hex), 32'({SB, S0, SB, S0}));
        check("async rst score", 32'(bus_a.score_bcd), 32'h0);
        check("async rst game_over", 32'(bus_a.game_over), 32'h0);
        check("async rst winner", 32'(bus_a.winner), 32'h0);
        #2 rst = 1'b0;

        run_rows(seg_b_start, rows.size() - 1);

        // Now one edge after game over with player 1 winning: watch the blink.
        for (int n = 2; n <= 13; n++) begin
            tick();
            if ((((n - 1) / 4) % 2) == 1)
                check($sformatf("blink n%0d p1", n), 32'(bus_a.hex[27:14]), 32'({SB, SB}));
            else
                check($sformatf("blink n%0d p1", n), 32'(bus_a.hex[27:14]), 32'({S1, S1}));
            check($sformatf("blink n%0d p0", n), 32'(bus_a.hex[13:0]), 32'({SB, S0}));
        end

        // clear wins over point while in the blank phase.
        bus_a.point = 2'b01;
        bus_a.clear = 1'b1;
        tick();
        bus_a.point = 2'b00;
        bus_a.clear = 1'b0;
        check("clear score", 32'(bus_a.score_bcd), 32'h0);
        check("clear game_over", 32'(bus_a.game_over), 32'h0);
        check("clear winner", 32'(bus_a.winner), 32'h0);
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("clear hex %0d", n), 32'(bus_a.hex), 32'({SB, S0, SB, S0}));
        end

        // One digit, no win limit: saturate at 9.
        for (int k = 1; k <= 12; k++) begin
            bus_b.point = 2'b01;
            tick();
            bus_b.point = 2'b00;
            check($sformatf("sat k%0d score", k), 32'(bus_b.score_bcd), 32'({4'h0, 4'(k > 9 ? 9 : k)}));
            check($sformatf("sat k%0d game_over", k), 32'(bus_b.game_over), 32'h0);
        end
        tick();
        check("sat hex", 32'(bus_b.hex), 32'({S0, S9}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pong_score_display.md
Name: pong_score_display

Overview:
- Parametrised score keeper and seven-segment driver for the Pong top level; replaces the fixed all-blank HEX assignments.
- Keeps a BCD score per player, detects the winning score and latches the winner.
- Drives active-low seven-segment digits, with optional leading-zero blanking and a blinking winner display.
- Sits between GameLogic (point pulses) and the HEX0..HEX7 board pins, clocked by clk_vga.

Parameters:
- PLAYERS, 2, number of score channels.
- DIGITS, 2, BCD digits per player. PLAYERS*DIGITS must be no more than 8.
- WIN_SCORE, 11, decimal winning score. 0 means no limit. Must not exceed 10^DIGITS-1; checked at elaboration.
- BLINK_DIV, 12_500_000, clk cycles per blink half-period. Must be at least 1.
- LZB, 1, 1 = blank leading zeros; the units digit is never blanked.

Ports:
- clk  input  1  system clock (clk_vga).
- rst  input  1  reset, asynchronous, active-high.
- point  input  PLAYERS  one-cycle pulse per bit; bit i scores one point for player i.
- clear  input  1  one-cycle pulse: new game.
- score_bcd  output  PLAYERS*DIGITS*4  raw BCD scores; player i occupies slice [i*DIGITS*4 +: DIGITS*4].
- game_over  output  1  a player has reached WIN_SCORE.
- winner  output  max(1,$clog2(PLAYERS))  index of the winning player; valid while game_over=1.
- hex  output  PLAYERS*DIGITS*7  active-low segments {g,f,e,d,c,b,a} per digit.
  - Digit d of player i is at [(i*DIGITS+d)*7 +: 7].
  - d=0 is the units digit.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - All scores 0.
  - game_over=0, winner=0.
  - Blink counter 0, blink phase = visible.
  - hex: units digits = 7'b1000000 ("0"). Other digits = 7'b1111111 if LZB=1, else 7'b1000000.
- Score update, on the edge after point[i]=1 with clear=0 and game_over=0:
  - Player i's score increments by one in BCD, rippling the carry through its digits.
  - At all-nines the score saturates and holds.
  - Each bit of point is handled independently, so simultaneous points increment every flagged player in the same cycle.
- clear:
  - On the next edge, scores go to 0, game_over to 0, winner to 0, and the blink state resets.
  - clear has priority over point in the same cycle.
- Win detection (WIN_SCORE != 0):
  - Compare the next-state score with the BCD constant of WIN_SCORE.
  - On the edge where one or more players reach it, set game_over=1 and set winner to the lowest index among them.
  - While game_over=1, point is ignored and scores are frozen.
- Blink:
  - While game_over=1, a counter runs 0..BLINK_DIV-1 and toggles the phase on wrap.
  - In the blank phase, all digits of the winner are 7'b1111111. Other players are shown steadily.
  - When game_over=0, the counter is held at 0 and the phase at visible.
- Latency:
  - score_bcd, game_over and winner are registered; they change one edge after the point or clear pulse.
  - hex is registered from the score state, so it updates one edge after score_bcd (two edges after the pulse).
- Leading-zero blanking (LZB=1): digit d>0 is blanked if it and all higher digits of that player are 0.
- Encoding: decoded digits 0-9 use the standard active-low patterns. Out-of-range codes cannot occur; the decoder maps them to blank.
- Reset mid-game or mid-blink: immediate return to the reset values with no residual blink state.

Decomposition:
- Shared package pong_pkg:
  - SEG_BLANK=7'b1111111.
  - SEG_DIGIT[0:9] patterns.
  - Constant function to_bcd(value, digits) used to build the WIN_SCORE comparison constant.
- One sub-module, seg7_decoder:
  - Combinational, 4-bit BCD plus a blank flag in, 7-bit active-low segments out.
  - Instantiated PLAYERS*DIGITS times through a generate loop.

Test Plan:
1. Assert rst asynchronously mid-cycle (defaults) -> hex = {1111111,1000000,1111111,1000000}, game_over=0, winner=0, without waiting for a clk edge.
2. Ten point[0] pulses -> score_bcd player0 = 8'h10; two edges after the last pulse, hex digit1 = 7'b1111001 and digit0 = 7'b1000000.
3. WIN_SCORE=11, BLINK_DIV=4; eleven point[1] pulses:
   - Edge after the 11th pulse: game_over=1, winner=1.
   - A 12th pulse leaves the score at 8'h11.
   - Player1 digits alternate blank/visible every 4 cycles; player0 is steady.
4. Both players at 10, then point=2'b11 in one cycle -> both at 8'h11, game_over=1, winner=0.
5. clear and point[0] in the same cycle during blinking -> all scores 0, game_over=0, blink stopped, hex back to the reset pattern.
6. DIGITS=1, WIN_SCORE=0, twelve point[0] pulses -> score saturates at 4'h9, hex digit = 7'b0010000, game_over stays 0.
